prefetch_fetcher: RTL and testbench

//   Per-warp instruction fetcher with a DEPTH-entry sequential prefetch queue. It sits between the warp

---
 rtl/prefetch_fetcher_pkg.sv | 23 ++
 rtl/prefetch_fetcher_queue.sv | 85 ++++++++
 rtl/prefetch_fetcher.sv | 178 +++++++++++++++++
 tb/tb_prefetch_fetcher.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prefetch_fetcher_pkg.sv
// Shared types for the per-warp prefetching instruction fetcher: fetcher/warp state encodings,
// request tags and the default prefetch depth.
package prefetch_fetcher_pkg;

  localparam int DEFAULT_PREFETCH_DEPTH = 4;

  typedef logic [1:0] fetcher_state_t;
  localparam fetcher_state_t FETCHER_IDLE     = 2'd0;
  localparam fetcher_state_t FETCHER_FETCHING = 2'd1;
  localparam fetcher_state_t FETCHER_DONE     = 2'd2;

  typedef logic [2:0] warp_state_t;
  localparam warp_state_t WARP_IDLE   = 3'd0;
  localparam warp_state_t WARP_FETCH  = 3'd1;
  localparam warp_state_t WARP_DECODE = 3'd2;

  typedef enum logic [1:0] {
    TAG_DEMAND   = 2'd0,
    TAG_PREFETCH = 2'd1,
    TAG_DISCARD  = 2'd2
  } fetch_tag_t;

endpackage

// File: rtl/prefetch_fetcher_queue.sv
// In-order prefetch queue of {addr, instr} entries with wrap-around pointers.
// Flush beats push and pop; a push into a full queue is accepted only alongside a pop.
module prefetch_fetcher_queue #(
  parameter int DEPTH       = 4,
  parameter int ADDR_WIDTH  = 8,
  parameter int INSTR_WIDTH = 16,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [ADDR_WIDTH-1:0]  push_addr,
  input  logic [INSTR_WIDTH-1:0] push_instr,
  input  logic                   pop,
  input  logic                   flush,
  output logic [ADDR_WIDTH-1:0]  head_addr,
  output logic [INSTR_WIDTH-1:0] head_instr,
  output logic [CW-1:0]          count
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [ADDR_WIDTH-1:0]  addr_q  [DEPTH];
  logic [ADDR_WIDTH-1:0]  addr_d  [DEPTH];
  logic [INSTR_WIDTH-1:0] instr_q [DEPTH];
  logic [INSTR_WIDTH-1:0] instr_d [DEPTH];
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   do_pop, do_push;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != FULL_CNT) || do_pop);

  always_comb begin
    addr_d   = addr_q;
    instr_d  = instr_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        addr_d[wr_ptr_q]  = push_addr;
        instr_d[wr_ptr_q] = push_instr;
        wr_ptr_d          = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i]  <= '0;
        instr_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      addr_q   <= addr_d;
      instr_q  <= instr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_addr  = addr_q[rd_ptr_q];
  assign head_instr = instr_q[rd_ptr_q];
  assign count      = count_q;

endmodule

// File: rtl/prefetch_fetcher.sv
// Per-warp instruction fetcher: sequential PCs are served from a prefetch queue in one cycle,
// anything else flushes the queue and refetches from the demand address.
module prefetch_fetcher
  import prefetch_fetcher_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_PREFETCH_DEPTH,
  parameter int ADDR_WIDTH  = 8,
  parameter int INSTR_WIDTH = 16,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  warp_state_t            warp_state,
  input  logic [ADDR_WIDTH-1:0]  pc,
  input  logic                   prefetch_enable,
  input  logic                   instruction_mem_read_ready,
  input  logic [INSTR_WIDTH-1:0] instruction_mem_read_data,
  output logic                   instruction_mem_read_valid,
  output logic [ADDR_WIDTH-1:0]  instruction_mem_read_address,
  output fetcher_state_t         fetcher_state,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [CW-1:0]          queue_count,
  output logic                   prefetch_hit
);

  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  // Memory handshake: one read outstanding at most. valid/address hold until a cycle with
  // ready=1, which completes the read; valid is low on the following cycle. ready is
  // meaningless while valid=0.
  fetcher_state_t         state_q, state_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   valid_q, valid_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  fetch_tag_t             tag_q, tag_d;
  logic [ADDR_WIDTH-1:0]  next_addr_q, next_addr_d;
  logic                   dpend_q, dpend_d;
  logic [ADDR_WIDTH-1:0]  daddr_q, daddr_d;
  logic                   hit_q, hit_d;

  logic                   q_push, q_pop, q_flush;
  logic [ADDR_WIDTH-1:0]  q_head_addr;
  logic [INSTR_WIDTH-1:0] q_head_instr;
  logic [CW-1:0]          q_count;
  logic                   resp, idle_fetch, hit, miss;

  prefetch_fetcher_queue #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .INSTR_WIDTH(INSTR_WIDTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (q_push),
    .push_addr (addr_q),
    .push_instr(instruction_mem_read_data),
    .pop       (q_pop),
    .flush     (q_flush),
    .head_addr (q_head_addr),
    .head_instr(q_head_instr),
    .count     (q_count)
  );

  assign resp       = valid_q && instruction_mem_read_ready;
  assign idle_fetch = (state_q == FETCHER_IDLE) && (warp_state == WARP_FETCH);
  assign hit        = idle_fetch && (q_count != '0) && (q_head_addr == pc);
  assign miss       = idle_fetch && !hit;

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    addr_d      = addr_q;
    tag_d       = tag_q;
    next_addr_d = next_addr_q;
    dpend_d     = dpend_q;
    daddr_d     = daddr_q;
    hit_d       = 1'b0;
    q_push      = 1'b0;
    q_pop       = 1'b0;
    q_flush     = 1'b0;

    if (resp) begin
      valid_d = 1'b0;
      case (tag_q)
        TAG_DEMAND: begin
          instr_d = instruction_mem_read_data;
          state_d = FETCHER_DONE;
        end
        TAG_PREFETCH: begin
          q_push      = 1'b1;
          next_addr_d = addr_q + 1'b1;
        end
        default: ;
      endcase
    end

    case (state_q)
      FETCHER_IDLE: begin
        if (hit) begin
          instr_d = q_head_instr;
          q_pop   = 1'b1;
          hit_d   = 1'b1;
          state_d = FETCHER_DONE;
        end else if (miss) begin
          // Flush also drops a prefetch response landing this same cycle.
          q_flush     = 1'b1;
          next_addr_d = pc + 1'b1;
          state_d     = FETCHER_FETCHING;
          if (valid_q && !resp) begin
            if (addr_q == pc) begin
              tag_d = TAG_DEMAND;
            end else begin
              tag_d   = TAG_DISCARD;
              dpend_d = 1'b1;
              daddr_d = pc;
            end
          end else if (valid_q) begin
            dpend_d = 1'b1;
            daddr_d = pc;
          end else begin
            valid_d = 1'b1;
            addr_d  = pc;
            tag_d   = TAG_DEMAND;
          end
        end
      end
      FETCHER_DONE: begin
        if (warp_state == WARP_DECODE) state_d = FETCHER_IDLE;
      end
      default: ;
    endcase

    // A deferred demand always wins the free port over a prefetch.
    if (!valid_q && dpend_q) begin
      valid_d = 1'b1;
      addr_d  = daddr_q;
      tag_d   = TAG_DEMAND;
      dpend_d = 1'b0;
    end else if (!valid_q && !miss && prefetch_enable && (q_count < DEPTH_CNT)) begin
      valid_d = 1'b1;
      addr_d  = next_addr_q;
      tag_d   = TAG_PREFETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FETCHER_IDLE;
      instr_q     <= '0;
      valid_q     <= 1'b0;
      addr_q      <= '0;
      tag_q       <= TAG_DEMAND;
      next_addr_q <= '0;
      dpend_q     <= 1'b0;
      daddr_q     <= '0;
      hit_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      addr_q      <= addr_d;
      tag_q       <= tag_d;
      next_addr_q <= next_addr_d;
      dpend_q     <= dpend_d;
      daddr_q     <= daddr_d;
      hit_q       <= hit_d;
    end
  end

  assign instruction_mem_read_valid   = valid_q;
  assign instruction_mem_read_address = addr_q;
  assign fetcher_state                = state_q;
  assign instruction                  = instr_q;
  assign queue_count                  = q_count;
  assign prefetch_hit                 = hit_q;

endmodule

// File: tb/tb_prefetch_fetcher.sv
// Directed and randomized bench for prefetch_fetcher: a latency-programmable memory responder,
// a request log, and a settled-queue reference model for random sequential/branch fetches.
module tb_prefetch_fetcher;
  import prefetch_fetcher_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 8;
  localparam int IW    = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic           clk = 1'b0;
  logic           reset;
  warp_state_t    warp_state;
  logic [AW-1:0]  pc;
  logic           prefetch_enable;
  logic           mem_ready;
  logic [IW-1:0]  mem_rdata;
  logic           mem_valid;
  logic [AW-1:0]  mem_addr;
  fetcher_state_t fetcher_state;
  logic [IW-1:0]  instruction;
  logic [CW-1:0]  queue_count;
  logic           prefetch_hit;

  int             errors = 0;
  int             checks = 0;
  int             lat = 0;
  logic [AW-1:0]  req_log[$];
  logic [IW-1:0]  exp_q[$];

  prefetch_fetcher #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW),
    .INSTR_WIDTH(IW)
  ) dut (
    .clk                         (clk),
    .reset                       (reset),
    .warp_state                  (warp_state),
    .pc                          (pc),
    .prefetch_enable             (prefetch_enable),
    .instruction_mem_read_ready  (mem_ready),
    .instruction_mem_read_data   (mem_rdata),
    .instruction_mem_read_valid  (mem_valid),
    .instruction_mem_read_address(mem_addr),
    .fetcher_state               (fetcher_state),
    .instruction                 (instruction),
    .queue_count                 (queue_count),
    .prefetch_hit                (prefetch_hit)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, required finish)");
    $fatal(1, "watchdog");
  end

  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    return {a ^ 8'h5A, a};
  endfunction

  // Memory responder: ready for one cycle, `lat` cycles after valid is first seen.
  initial begin
    int cnt;
    cnt = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_ready) begin
        mem_ready = 1'b0;
        cnt = 0;
      end else if (mem_valid) begin
        if (cnt >= lat) begin
          mem_ready = 1'b1;
          mem_rdata = mem_word(mem_addr);
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Request log: a new request starts when valid rises or follows a completed read.
  initial begin
    logic pv, pr;
    pv = 1'b0;
    pr = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_valid && (!pv || pr)) req_log.push_back(mem_addr);
      pv = mem_valid;
      pr = mem_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_fetch(input logic [AW-1:0] a, output int cyc, output logic hit, output int cnt1);
    warp_state = WARP_FETCH;
    pc = a;
    cyc = 0;
    cnt1 = -1;
    do begin
      tick();
      cyc++;
      if (cyc == 1) cnt1 = int'(queue_count);
    end while (fetcher_state != FETCHER_DONE && cyc < 200);
    chk("fetch_done", 32'(fetcher_state), 32'(FETCHER_DONE));
    hit = prefetch_hit;
  endtask

  task automatic release_done();
    warp_state = WARP_DECODE;
    tick();
    warp_state = WARP_IDLE;
    chk("release_idle", 32'(fetcher_state), 32'(FETCHER_IDLE));
  endtask

  task automatic wait_settled();
    int n = 0;
    while (!(queue_count == CW'(DEPTH) && !mem_valid) && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_inflight(input logic [AW-1:0] a);
    int n = 0;
    while (!(mem_valid && mem_addr == a) && n < 100) begin
      tick();
      n++;
    end
    chk("inflight_addr", {mem_valid, mem_addr}, {1'b1, a});
  endtask

  task automatic wait_bus_idle();
    int n = 0;
    while (mem_valid && n < 100) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int cyc, cnt1, n0, n;
    logic hit, exp_hit;
    logic [AW-1:0] a, base;
    logic [IW-1:0] e;
    int sel;

    reset = 1'b1;
    warp_state = WARP_IDLE;
    pc = '0;
    prefetch_enable = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_valid", mem_valid, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_state", 32'(fetcher_state), 32'(FETCHER_IDLE));
    chk("rst_instr", instruction, 0);
    chk("rst_count", queue_count, 0);
    chk("rst_hit", prefetch_hit, 0);

    // 1. Cold start, demand-only, memory ready 2 cycles after valid.
    lat = 2;
    do_fetch(8'h10, cyc, hit, cnt1);
    chk("cold_latency", cyc, 4);
    chk("cold_req_count", req_log.size(), 1);
    chk("cold_req_addr", req_log[0], 8'h10);
    chk("cold_instr", instruction, mem_word(8'h10));
    chk("cold_hit", hit, 0);
    release_done();

    // 2. Sequential run: fill 0x11..0x14, then hit 0x11 and refill 0x15.
    lat = 0;
    req_log.delete();
    prefetch_enable = 1'b1;
    wait_settled();
    chk("fill_count", queue_count, DEPTH);
    chk("fill_reqs", req_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("fill_addr", req_log[i], 8'h11 + i);
    do_fetch(8'h11, cyc, hit, cnt1);
    chk("seq_latency", cyc, 1);
    chk("seq_hit", hit, 1);
    chk("seq_count_after_pop", cnt1, 3);
    chk("seq_instr", instruction, mem_word(8'h11));
    n = 0;
    while (req_log.size() < 5 && n < 10) begin
      tick();
      n++;
    end
    chk("seq_refill_addr", req_log[4], 8'h15);
    release_done();

    // 3. Branch to 0x40 while prefetch of 0x13 is in flight.
    lat = 3;
    do_fetch(8'h11, cyc, hit, cnt1);
    chk("br_setup_instr", instruction, mem_word(8'h11));
    release_done();
    wait_inflight(8'h13);
    do_fetch(8'h40, cyc, hit, cnt1);
    chk("br_flush_count", cnt1, 0);
    chk("br_hit", hit, 0);
    chk("br_instr", instruction, mem_word(8'h40));
    chk("br_count_done", queue_count, 0);
    n0 = req_log.size();
    chk("br_discarded_req", req_log[n0-2], 8'h13);
    chk("br_demand_req", req_log[n0-1], 8'h40);
    n = 0;
    while (req_log.size() == n0 && n < 20) begin
      tick();
      n++;
    end
    chk("br_resume_addr", req_log[n0], 8'h41);
    release_done();

    // 4. Branch to the address already in flight (0x22); head 0x21 is a non-head miss.
    do_fetch(8'h20, cyc, hit, cnt1);
    release_done();
    wait_inflight(8'h22);
    tick();
    n0 = req_log.size();
    chk("retag_last_req", req_log[n0-1], 8'h22);
    do_fetch(8'h22, cyc, hit, cnt1);
    chk("retag_no_new_req", req_log.size(), n0);
    chk("retag_instr", instruction, mem_word(8'h22));
    chk("retag_hit", hit, 0);
    chk("retag_flush_count", cnt1, 0);
    release_done();

    // 5. Address wrap from 0xFE.
    lat = 0;
    do_fetch(8'hFE, cyc, hit, cnt1);
    n0 = req_log.size();
    release_done();
    wait_settled();
    chk("wrap_req0", req_log[n0], 8'hFF);
    chk("wrap_req1", req_log[n0+1], 8'h00);
    chk("wrap_req2", req_log[n0+2], 8'h01);
    do_fetch(8'hFF, cyc, hit, cnt1);
    chk("wrap_hit", hit, 1);
    chk("wrap_latency", cyc, 1);
    chk("wrap_instr", instruction, mem_word(8'hFF));
    release_done();

    // 6. Prefetch disabled: queued entries stay usable, every other fetch is a demand miss.
    prefetch_enable = 1'b0;
    wait_bus_idle();
    n0 = req_log.size();
    do_fetch(8'h00, cyc, hit, cnt1);
    chk("dis_queued_hit", hit, 1);
    chk("dis_queued_instr", instruction, mem_word(8'h00));
    release_done();
    do_fetch(8'h80, cyc, hit, cnt1);
    chk("dis_hit_80", hit, 0);
    release_done();
    do_fetch(8'h81, cyc, hit, cnt1);
    chk("dis_hit_81", hit, 0);
    chk("dis_instr_81", instruction, mem_word(8'h81));
    release_done();
    repeat (4) tick();
    chk("dis_req_count", req_log.size(), n0 + 2);
    chk("dis_req0", req_log[n0], 8'h80);
    chk("dis_req1", req_log[n0+1], 8'h81);
    chk("dis_valid_quiet", mem_valid, 0);

    // Reset while a read is outstanding and the queue holds data.
    prefetch_enable = 1'b1;
    lat = 3;
    n = 0;
    while (!(mem_valid && queue_count != '0) && n < 100) begin
      tick();
      n++;
    end
    chk("mid_valid_before", mem_valid, 1);
    reset = 1'b1;
    tick();
    chk("mid_rst_valid", mem_valid, 0);
    chk("mid_rst_state", 32'(fetcher_state), 32'(FETCHER_IDLE));
    chk("mid_rst_count", queue_count, 0);
    chk("mid_rst_hit", prefetch_hit, 0);
    reset = 1'b0;

    // Random phase: after settling the queue holds base..base+DEPTH-1.
    base = 8'h00;
    for (int it = 0; it < 24; it++) begin
      lat = $urandom_range(0, 3);
      wait_settled();
      chk("rnd_settle_count", queue_count, DEPTH);
      sel = $urandom_range(0, 3);
      if (sel < 2) a = base;
      else if (sel == 2) a = base + 8'd1;
      else a = 8'($urandom_range(0, 255));
      exp_hit = (a == base);
      exp_q.push_back(mem_word(a));
      do_fetch(a, cyc, hit, cnt1);
      chk("rnd_hit", hit, exp_hit);
      if (exp_hit) chk("rnd_hit_latency", cyc, 1);
      e = exp_q.pop_front();
      chk("rnd_instr", instruction, e);
      base = a + 8'd1;
      release_done();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
